// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: operation
// encoding, FSM states, flag bit positions and the default operand width.
package muldiv_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic {
        OpMul = 1'b0,
        OpDiv = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StWb   = 2'd2
    } state_e;

    localparam int unsigned FlagZ   = 0;
    localparam int unsigned FlagV   = 1;
    localparam int unsigned FlagDz  = 2;
    localparam int unsigned FlagErr = 7;

    // Assemble the flag byte; unused bits stay zero.
    function automatic logic [7:0] pack_flags(input logic z, input logic v, input logic dz,
                                              input logic err);
        logic [7:0] f;
        f          = '0;
        f[FlagZ]   = z;
        f[FlagV]   = v;
        f[FlagDz]  = dz;
        f[FlagErr] = err;
        return f;
    endfunction

endpackage

// File: rtl/mul_div_seq_if.sv
// Request/result bundle of mul_div_seq. The master drives the operation
// request; the slave (the unit itself) returns status, strobes and results.
interface mul_div_seq_if
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             IMUL;
    logic             IDIV;
    logic [WIDTH-1:0] DinA;
    logic [WIDTH-1:0] Dhi;
    logic [7:0]       Flags_in_alu;

    modport master (
        output start, op, A, B,
        input  busy, done, IMUL, IDIV, DinA, Dhi, Flags_in_alu
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, IMUL, IDIV, DinA, Dhi, Flags_in_alu
    );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the sequential unit.
// Multiply: shift-add on a 2*Width accumulator {hi, lo}; lo starts as the
// multiplier and is consumed LSB first while the product fills in from the top.
// Divide (MUL_DIV_SEQ_DIV_EN only): restoring step on a Width+1 partial
// remainder; acc lo starts as the dividend and becomes the quotient, MSB first.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned Width = DefaultWidth
) (
`ifdef MUL_DIV_SEQ_DIV_EN
    input  op_e              op_i,
    input  logic [Width:0]   rem_i,
    output logic [Width:0]   rem_o,
`endif
    input  logic [Width-1:0]   opnd_i,
    input  logic [2*Width-1:0] acc_i,
    output logic [2*Width-1:0] acc_o
);

    logic [Width:0]     mul_sum;
    logic [2*Width-1:0] mul_acc;

    // Add the multiplicand when the current multiplier bit is set, then shift right.
    always_comb begin
        mul_sum = {1'b0, acc_i[2*Width-1:Width]};
        if (acc_i[0]) begin
            mul_sum = mul_sum + {1'b0, opnd_i};
        end
        mul_acc = {mul_sum, acc_i[Width-1:1]};
    end

`ifdef MUL_DIV_SEQ_DIV_EN
    logic [Width:0]   div_shift;
    logic [Width:0]   div_diff;
    logic [Width-1:0] div_q;
    logic             unused_rem_msb;

    // The remainder is always below the divisor, so its top bit never feeds the shift.
    assign unused_rem_msb = rem_i[Width];

    // Shift in the next dividend bit, trial-subtract, restore when negative.
    always_comb begin
        div_shift = {rem_i[Width-1:0], acc_i[Width-1]};
        div_diff  = div_shift - {1'b0, opnd_i};
        if (div_diff[Width]) begin
            rem_o = div_shift;
            div_q = {acc_i[Width-2:0], 1'b0};
        end else begin
            rem_o = div_diff;
            div_q = {acc_i[Width-2:0], 1'b1};
        end
        acc_o = (op_i == OpDiv) ? {{Width{1'b0}}, div_q} : mul_acc;
    end
`else
    assign acc_o = mul_acc;
`endif

endmodule

// File: rtl/mul_div_seq.sv
// Sequential unsigned multiply/divide unit: one operand bit per cycle, results
// written back with a one-cycle done pulse and an IMUL/IDIV register-load strobe.
// Optional divide datapath: define MUL_DIV_SEQ_DIV_EN. Without it a divide
// request completes immediately with ERR set and no strobe.
module mul_div_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input logic          clk,
    input logic          rst,
    mul_div_seq_if.slave bus
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               imul_q, imul_d;
    logic               idiv_q, idiv_d;
    logic [WIDTH-1:0]   dina_q, dina_d;
    logic [WIDTH-1:0]   dhi_q, dhi_d;
    logic [7:0]         flags_q, flags_d;
    logic [2*WIDTH-1:0] step_acc;
`ifdef MUL_DIV_SEQ_DIV_EN
    op_e                op_q, op_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH:0]     step_rem;
`endif

    muldiv_step #(
        .Width (WIDTH)
    ) u_step (
`ifdef MUL_DIV_SEQ_DIV_EN
        .op_i   (op_q),
        .rem_i  (rem_q),
        .rem_o  (step_rem),
`endif
        .opnd_i (opnd_q),
        .acc_i  (acc_q),
        .acc_o  (step_acc)
    );

    // Next-state and registered-output logic of the IDLE/RUN/WB sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        imul_d  = 1'b0;
        idiv_d  = 1'b0;
        dina_d  = dina_q;
        dhi_d   = dhi_q;
        flags_d = flags_q;
`ifdef MUL_DIV_SEQ_DIV_EN
        op_d    = op_q;
        rem_d   = rem_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    if (op_e'(bus.op) == OpMul) begin
                        state_d = StRun;
                        opnd_d  = bus.A;
                        acc_d   = {{WIDTH{1'b0}}, bus.B};
`ifdef MUL_DIV_SEQ_DIV_EN
                        op_d    = OpMul;
`endif
                    end else begin
`ifdef MUL_DIV_SEQ_DIV_EN
                        op_d = OpDiv;
                        if (bus.B == '0) begin
                            // Divide by zero skips the iterations entirely.
                            state_d = StWb;
                            done_d  = 1'b1;
                            idiv_d  = 1'b1;
                            dina_d  = '1;
                            dhi_d   = bus.A;
                            flags_d = pack_flags(1'b0, 1'b0, 1'b1, 1'b0);
                        end else begin
                            state_d = StRun;
                            opnd_d  = bus.B;
                            acc_d   = {{WIDTH{1'b0}}, bus.A};
                            rem_d   = '0;
                        end
`else
                        state_d = StWb;
                        done_d  = 1'b1;
                        dina_d  = '0;
                        dhi_d   = '0;
                        flags_d = pack_flags(1'b1, 1'b0, 1'b0, 1'b1);
`endif
                    end
                end
            end
            StRun: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
`ifdef MUL_DIV_SEQ_DIV_EN
                rem_d = step_rem;
`endif
                if (cnt_q == CntLast) begin
                    state_d = StWb;
                    done_d  = 1'b1;
                    dina_d  = step_acc[WIDTH-1:0];
`ifdef MUL_DIV_SEQ_DIV_EN
                    if (op_q == OpDiv) begin
                        idiv_d  = 1'b1;
                        dhi_d   = step_rem[WIDTH-1:0];
                        flags_d = pack_flags(step_acc[WIDTH-1:0] == '0, 1'b0, 1'b0, 1'b0);
                    end else
`endif
                    begin
                        imul_d  = 1'b1;
                        dhi_d   = step_acc[2*WIDTH-1:WIDTH];
                        flags_d = pack_flags(step_acc[WIDTH-1:0] == '0,
                                             |step_acc[2*WIDTH-1:WIDTH], 1'b0, 1'b0);
                    end
                end
            end
            StWb: begin
                // Start is ignored here; busy drops as the unit returns to idle.
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            imul_q  <= 1'b0;
            idiv_q  <= 1'b0;
            dina_q  <= '0;
            dhi_q   <= '0;
            flags_q <= '0;
`ifdef MUL_DIV_SEQ_DIV_EN
            op_q    <= OpMul;
            rem_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            imul_q  <= imul_d;
            idiv_q  <= idiv_d;
            dina_q  <= dina_d;
            dhi_q   <= dhi_d;
            flags_q <= flags_d;
`ifdef MUL_DIV_SEQ_DIV_EN
            op_q    <= op_d;
            rem_q   <= rem_d;
`endif
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.IMUL         = imul_q;
    assign bus.IDIV         = idiv_q;
    assign bus.DinA         = dina_q;
    assign bus.Dhi          = dhi_q;
    assign bus.Flags_in_alu = flags_q;

endmodule
